// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// the divide-by-zero quotient pattern and the iteration counter sizing.
package div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Wide all-ones pattern; users slice it down to their operand width.
  localparam logic [63:0] DIV0_QUOT = '1;

  function automatic int cnt_width(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/start_edge.sv
// Registered rising-edge detector for the debounced start level.
module start_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= 1'b0;
    else        in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider: one shift-subtract step per clock, results
// held stable for the display until the next operation completes.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
  output logic [size-1:0] consult,
  output logic [size-1:0] remainder,
  output logic            busy,
  output logic            done,
  output logic            div_zero
);

  localparam int CW = cnt_width(size);
  localparam logic [CW-1:0] CNT_LAST = CW'(size - 1);

  logic start_pulse;

  state_t state_reg, state_next;
  logic [size-1:0] d_reg, d_next;
  logic [size:0]   r_reg, r_next;
  logic [size-1:0] q_reg, q_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [size-1:0] consult_reg, consult_next;
  logic [size-1:0] remainder_reg, remainder_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            div_zero_reg, div_zero_next;

  logic [size:0]   t;
  logic            ge;
  logic [size:0]   r_step;
  logic [size-1:0] q_step;

  start_edge u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (start),
    .pulse (start_pulse)
  );

  // Since r < d always holds, shifting one quotient bit in cannot overflow size+1 bits.
  always_comb begin
    t      = {r_reg[size-1:0], q_reg[size-1]};
    ge     = (t >= {1'b0, d_reg});
    r_step = ge ? (t - {1'b0, d_reg}) : t;
    q_step = {q_reg[size-2:0], ge};
  end

  always_comb begin
    state_next     = state_reg;
    d_next         = d_reg;
    r_next         = r_reg;
    q_next         = q_reg;
    cnt_next       = cnt_reg;
    consult_next   = consult_reg;
    remainder_next = remainder_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    div_zero_next  = div_zero_reg;

    case (state_reg)
      IDLE: begin
        if (start_pulse) begin
          if (divisor != '0) begin
            d_next        = divisor;
            r_next        = '0;
            q_next        = dividend;
            cnt_next      = '0;
            busy_next     = 1'b1;
            div_zero_next = 1'b0;
            state_next    = CALC;
          end else begin
            consult_next   = DIV0_QUOT[size-1:0];
            remainder_next = dividend;
            div_zero_next  = 1'b1;
            done_next      = 1'b1;
          end
        end
      end
      CALC: begin
        r_next   = r_step;
        q_next   = q_step;
        cnt_next = cnt_reg + CW'(1);
        // Outputs only change here, so the display never sees partial results.
        if (cnt_reg == CNT_LAST) begin
          consult_next   = q_step;
          remainder_next = r_step[size-1:0];
          done_next      = 1'b1;
          busy_next      = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      d_reg         <= '0;
      r_reg         <= '0;
      q_reg         <= '0;
      cnt_reg       <= '0;
      consult_reg   <= '0;
      remainder_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      div_zero_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      d_reg         <= d_next;
      r_reg         <= r_next;
      q_reg         <= q_next;
      cnt_reg       <= cnt_next;
      consult_reg   <= consult_next;
      remainder_reg <= remainder_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      div_zero_reg  <= div_zero_next;
    end
  end

  assign consult   = consult_reg;
  assign remainder = remainder_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases plus random operands
// compared against plain integer division.
module tb_div_seq_ctrl;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [SIZE-1:0] dividend = '0;
  logic [SIZE-1:0] divisor = '0;
  logic [SIZE-1:0] consult;
  logic [SIZE-1:0] remainder;
  logic            busy;
  logic            done;
  logic            div_zero;

  int checks = 0;
  int failures = 0;
  logic [SIZE-1:0] last_q = '0;
  logic [SIZE-1:0] last_r = '0;

  div_seq_ctrl #(.size(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .consult   (consult),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation: press start, watch until done, compare with a/b and a%b.
  task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input bit disturb, input int hold_extra);
    logic [SIZE-1:0] eq, er;
    int lat, busy_n, extra_done;
    bit hold_ok, fin;
    eq = (b == 0) ? {SIZE{1'b1}} : SIZE'(int'(a) / int'(b));
    er = (b == 0) ? a : SIZE'(int'(a) % int'(b));
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    lat = 0; busy_n = 0; hold_ok = 1'b1; fin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin fin = 1'b1; break; end
      if (busy) busy_n++;
      if (consult !== last_q || remainder !== last_r) hold_ok = 1'b0;
      if (disturb && lat == 2) begin
        dividend = SIZE'($urandom); divisor = SIZE'($urandom); start = 1'b0;
      end
      if (disturb && lat == 4) start = 1'b1;
      @(posedge clk);
      lat++;
    end
    chk("done_seen", 32'(fin), 32'd1);
    chk("latency", 32'(lat), (b == 0) ? 32'd0 : 32'(SIZE));
    chk("busy_cycles", 32'(busy_n), (b == 0) ? 32'd0 : 32'(SIZE));
    chk("hold_old", 32'(hold_ok), 32'd1);
    chk("consult", 32'(consult), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_zero", 32'(div_zero), 32'(b == 0));
    chk("busy_at_done", 32'(busy), 32'd0);
    extra_done = 0;
    for (int i = 0; i < hold_extra + 1; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    chk("single_done", 32'(extra_done), 32'd0);
    $display("op %0d/%0d -> q=%0h r=%0h dz=%0b lat=%0d", a, b, consult, remainder, div_zero, lat);
    last_q = eq; last_r = er;
    start = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_consult", 32'(consult), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd100, 8'd7, 1'b0, 0);
    run_op(8'd255, 8'd1, 1'b0, 0);
    run_op(8'd3, 8'd10, 1'b0, 0);
    run_op(8'd5, 8'd0, 1'b0, 0);
    run_op(8'd9, 8'd3, 1'b0, 0);
    run_op(8'd77, 8'd5, 1'b0, 50);
    run_op(8'd250, 8'd13, 1'b1, 0);
    run_op(8'd0, 8'd0, 1'b0, 0);
    run_op(8'd128, 8'd255, 1'b1, 3);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd9; start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_consult", 32'(consult), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_flags", {29'd0, busy, done, div_zero}, 32'd0);
    $display("reset during CALC -> q=%0h r=%0h busy=%0b", consult, remainder, busy);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    last_q = '0; last_r = '0;
    run_op(8'd200, 8'd9, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      logic [SIZE-1:0] ra, rb;
      ra = SIZE'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : SIZE'($urandom);
      run_op(ra, rb, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
